// File: rtl/typing_pkg.sv
// rtl/typing_pkg.sv - shared letter codes, scan-code table and typist state encoding
package typing_pkg;

  localparam int MAX_LEN = 15;

  localparam logic [4:0] CODE_A = 5'd1;
  localparam logic [4:0] CODE_Z = 5'd26;

  localparam logic [6:0] SCAN_BACK  = 7'd102;
  localparam logic [6:0] SCAN_SPACE = 7'd41;

  // Keyboard scan codes for letters A..Z, indexed by code-1
  localparam logic [6:0] SCAN_TABLE [26] = '{
    7'd28, 7'd50, 7'd33, 7'd35, 7'd36, 7'd43, 7'd52, 7'd51, 7'd67,
    7'd59, 7'd66, 7'd75, 7'd58, 7'd49, 7'd68, 7'd77, 7'd21, 7'd45,
    7'd27, 7'd44, 7'd60, 7'd42, 7'd29, 7'd34, 7'd53, 7'd26
  };

  typedef enum logic [2:0] {
    GT_IDLE, GT_LOAD, GT_PRESS, GT_HOLD, GT_RELEASE, GT_GAP, GT_DONE
  } gt_state_e;

  // Plain constants for the state register, kept equal to the enum
  localparam logic [2:0] ST_IDLE    = 3'(GT_IDLE);
  localparam logic [2:0] ST_LOAD    = 3'(GT_LOAD);
  localparam logic [2:0] ST_PRESS   = 3'(GT_PRESS);
  localparam logic [2:0] ST_HOLD    = 3'(GT_HOLD);
  localparam logic [2:0] ST_RELEASE = 3'(GT_RELEASE);
  localparam logic [2:0] ST_GAP     = 3'(GT_GAP);
  localparam logic [2:0] ST_DONE    = 3'(GT_DONE);

  function automatic logic letter_ok(input logic [4:0] code);
    return (code >= CODE_A) && (code <= CODE_Z);
  endfunction

endpackage

// File: rtl/ghost_typist_if.sv
// rtl/ghost_typist_if.sv - keyboard event bus shared with the keyboard decoder
interface ghost_typist_if;
  logic [127:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid;

  modport master (output key_down, output last_change, output key_valid);
  modport slave  (input key_down, input last_change, input key_valid);
endinterface

// File: rtl/letter_to_scan.sv
// rtl/letter_to_scan.sv - letter code to keyboard scan code lookup
module letter_to_scan
  import typing_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] scan,
  output logic       valid
);

  // Table lookup guarded by the legal letter range
  always_comb begin
    valid = letter_ok(code);
    scan  = '0;
    if (valid) scan = SCAN_TABLE[code - CODE_A];
  end

endmodule

// File: rtl/ghost_typist.sv
// rtl/ghost_typist.sv - plays one dictionary word back as keyboard make/break events
module ghost_typist #(
  parameter int HOLD_TICKS = 2,
  parameter int GAP_TICKS  = 3,
  parameter int MAX_LEN    = typing_pkg::MAX_LEN
) (
  input  logic                 clk_div,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [5*MAX_LEN-1:0] word,
  input  logic [4:0]           wordnum,
  input  logic                 err_en,
  input  logic [3:0]           err_pos,
  ghost_typist_if.master       kbd,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           keys_sent
);
  import typing_pkg::*;

  localparam int CNT_MAX = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(MAX_LEN + 1);
  localparam int WORD_W  = 5 * MAX_LEN;

  // Typo progress: wrong letter sent -> BACK sent -> correction sent
  localparam logic [1:0] TY_NONE = 2'd0;
  localparam logic [1:0] TY_BACK = 2'd1;
  localparam logic [1:0] TY_FIX  = 2'd2;
  localparam logic [1:0] TY_DONE = 2'd3;

  logic [2:0]       state, nxt_state;
  logic [WORD_W-1:0] word_q;
  logic [IDX_W-1:0] len_q, idx_q, nxt_idx;
  logic             err_en_q;
  logic [3:0]       err_pos_q;
  logic [1:0]       typo_q, nxt_typo;
  logic             space_q, nxt_space, stop_q, nxt_stop;
  logic [CNT_W-1:0] cnt_q, nxt_cnt;
  logic [6:0]       scan_q, nxt_scan;

  logic              idle;
  logic [WORD_W-1:0] sel_word;
  logic [IDX_W-1:0]  sel_len, sel_idx, len_in;
  logic              sel_err_en, sel_space;
  logic [3:0]        sel_err_pos;
  logic [1:0]        sel_typo;

  logic              found;
  logic [IDX_W-1:0]  fidx;
  logic [4:0]        fcode, pick_code, wrap_code;
  logic [6:0]        right_scan, wrong_scan;
  logic              right_valid, wrong_valid;

  logic              ld_end, take_load, ld_space;
  logic [6:0]        ld_scan;
  logic [IDX_W-1:0]  ld_idx;
  logic [1:0]        ld_typo;

  assign len_in = (wordnum > 5'(MAX_LEN)) ? IDX_W'(MAX_LEN) : IDX_W'(wordnum);
  assign idle   = (state == ST_IDLE);

  // First key is chosen straight from the inputs so it appears the cycle after start
  always_comb begin
    sel_word    = idle ? word    : word_q;
    sel_len     = idle ? len_in  : len_q;
    sel_err_en  = idle ? err_en  : err_en_q;
    sel_err_pos = idle ? err_pos : err_pos_q;
    sel_idx     = idle ? '0      : idx_q;
    sel_typo    = idle ? TY_NONE : typo_q;
    sel_space   = idle ? 1'b0    : space_q;
  end

  // Find the first playable letter at or after the current index
  always_comb begin
    found = 1'b0;
    fidx  = '0;
    fcode = '0;
    for (int j = MAX_LEN - 1; j >= 0; j--) begin
      if (IDX_W'(j) >= sel_idx && IDX_W'(j) < sel_len && letter_ok(sel_word[5*j +: 5])) begin
        found = 1'b1;
        fidx  = IDX_W'(j);
        fcode = sel_word[5*j +: 5];
      end
    end
  end

  assign pick_code = (sel_typo == TY_FIX) ? sel_word[5*sel_idx +: 5] : fcode;
  assign wrap_code = (pick_code == CODE_Z) ? CODE_A : pick_code + 5'd1;

  letter_to_scan u_right (.code(pick_code), .scan(right_scan), .valid(right_valid));
  letter_to_scan u_wrong (.code(wrap_code), .scan(wrong_scan), .valid(wrong_valid));

  // Zero-cycle LOAD: decide the next key or the end of the word
  always_comb begin
    ld_end   = 1'b0;
    ld_scan  = scan_q;
    ld_idx   = sel_idx;
    ld_typo  = sel_typo;
    ld_space = sel_space;
    if (sel_typo == TY_BACK) begin
      ld_scan = SCAN_BACK;
      ld_typo = TY_FIX;
    end else if (sel_typo == TY_FIX) begin
      ld_scan = right_scan;
      ld_typo = TY_DONE;
      ld_idx  = sel_idx + 1'b1;
    end else if (found && right_valid) begin
      if (sel_err_en && sel_typo == TY_NONE && IDX_W'(sel_err_pos) == fidx && wrong_valid) begin
        ld_scan = wrong_scan;
        ld_typo = TY_BACK;
        ld_idx  = fidx;
      end else begin
        ld_scan = right_scan;
        ld_idx  = fidx + 1'b1;
      end
    end else if (!sel_space) begin
      ld_scan  = SCAN_SPACE;
      ld_space = 1'b1;
    end else begin
      ld_end = 1'b1;
    end
  end

  // Playback sequencing; stop overrides the normal flow
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx_q;
    nxt_typo  = typo_q;
    nxt_space = space_q;
    nxt_stop  = stop_q;
    nxt_cnt   = cnt_q;
    nxt_scan  = scan_q;
    take_load = 1'b0;
    case (state)
      ST_IDLE: begin
        nxt_stop = 1'b0;
        if (start) take_load = 1'b1;
      end
      ST_PRESS: begin
        if (stop) begin
          nxt_state = ST_RELEASE;
          nxt_stop  = 1'b1;
        end else begin
          nxt_state = ST_HOLD;
          nxt_cnt   = CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (stop) begin
          nxt_state = ST_RELEASE;
          nxt_stop  = 1'b1;
        end else if (cnt_q >= CNT_W'(HOLD_TICKS)) begin
          nxt_state = ST_RELEASE;
        end else begin
          nxt_cnt = cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (stop || stop_q) begin
          nxt_state = ST_DONE;
        end else begin
          nxt_state = ST_GAP;
          nxt_cnt   = CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (stop) nxt_state = ST_DONE;
        else if (cnt_q >= CNT_W'(GAP_TICKS)) take_load = 1'b1;
        else nxt_cnt = cnt_q + 1'b1;
      end
      ST_DONE: nxt_state = ST_IDLE;
      default: nxt_state = ST_IDLE;
    endcase
    if (take_load) begin
      nxt_state = ld_end ? ST_DONE : ST_PRESS;
      nxt_scan  = ld_end ? scan_q : ld_scan;
      nxt_idx   = ld_idx;
      nxt_typo  = ld_typo;
      nxt_space = ld_space;
    end
  end

  // Sequencer state and the word latched at start
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      word_q    <= '0;
      len_q     <= '0;
      err_en_q  <= 1'b0;
      err_pos_q <= '0;
      idx_q     <= '0;
      typo_q    <= TY_NONE;
      space_q   <= 1'b0;
      stop_q    <= 1'b0;
      cnt_q     <= '0;
      scan_q    <= '0;
    end else begin
      state   <= nxt_state;
      idx_q   <= nxt_idx;
      typo_q  <= nxt_typo;
      space_q <= nxt_space;
      stop_q  <= nxt_stop;
      cnt_q   <= nxt_cnt;
      scan_q  <= nxt_scan;
      if (idle && start) begin
        word_q    <= word;
        len_q     <= len_in;
        err_en_q  <= err_en;
        err_pos_q <= err_pos;
      end
    end
  end

  // Registered outputs derived from the state being entered
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      kbd.key_down    <= '0;
      kbd.last_change <= '0;
      kbd.key_valid   <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      keys_sent       <= '0;
    end else begin
      kbd.key_down  <= (nxt_state == ST_PRESS || nxt_state == ST_HOLD) ? (128'd1 << nxt_scan) : '0;
      kbd.key_valid <= (nxt_state == ST_PRESS || nxt_state == ST_RELEASE);
      if (nxt_state == ST_PRESS || nxt_state == ST_RELEASE) kbd.last_change <= {2'b00, nxt_scan};
      busy <= (nxt_state == ST_PRESS || nxt_state == ST_HOLD ||
               nxt_state == ST_RELEASE || nxt_state == ST_GAP);
      done <= (nxt_state == ST_DONE);
      if (idle && start) keys_sent <= 8'd1;
      else if (nxt_state == ST_PRESS && keys_sent != 8'hFF) keys_sent <= keys_sent + 8'd1;
    end
  end

endmodule

// File: doc/ghost_typist.md
Name: ghost_typist

Overview:
- Keystroke source for demo and self-test mode. Plays back one dictionary word as a stream of keyboard make/break events on the same interface the keyboard decoder drives: key_down, last_change, key_valid.
- Sits between the dictionary and the game-counting logic, in place of the keyboard decoder. Types each letter, optionally injects one typo plus backspace, then finishes with a space.

Parameters:
- HOLD_TICKS, 2, clk_div cycles a key stays down between its make and break events (>=1)
- GAP_TICKS, 3, idle clk_div cycles after each break event (>=1)
- MAX_LEN, 15, maximum letters per word; word bus is 5*MAX_LEN bits

Ports:
- clk_div  in  1  game tick clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  level; sampled only in IDLE; begins playback
- stop  in  1  synchronous abort request
- word  in  75  letter codes, 5 bits each, char i at [5i+4:5i]; 1=A..26=Z
- wordnum  in  5  word length in letters
- err_en  in  1  enable typo injection
- err_pos  in  4  letter index at which the typo is injected
- key_down  out  128  one-hot key-held vector, indexed by scan code
- last_change  out  9  scan code of the latest event; bits [8:7] are always 0
- key_valid  out  1  one-cycle strobe per make or break event
- busy  out  1  high from the cycle after start is accepted through the final gap
- done  out  1  one-cycle pulse when playback completes
- keys_sent  out  8  count of make events in the current playback; cleared on start

Behaviour:
- All outputs are registered. Reset value of every output is 0; state resets to IDLE.
- Scan-code map, letters A..Z: 28,50,33,35,36,43,52,51,67,59,66,75,58,49,68,77,21,45,27,44,60,42,29,34,53,26. BACK=102, SPACE=41.
- States: IDLE, LOAD, PRESS, HOLD, RELEASE, GAP, DONE.
- IDLE: when start=1, latch word, min(wordnum, MAX_LEN), err_en and err_pos; clear keys_sent; go to LOAD.
- LOAD (0 cycles visible): select the next key.
  - At letter index i < len with code 1..26:
    - If err_en and i==err_pos and the typo is not yet done, emit the wrong letter (code+1, 26 wraps to 1), then BACK, then the correct letter.
    - Otherwise emit the correct letter.
  - Codes 0 or >26 are skipped: no event, no gap.
  - At i==len, emit SPACE.
  - After the SPACE gap, go to DONE.
- PRESS, 1 cycle: key_down[code]=1, last_change=code, key_valid=1, keys_sent+1.
- HOLD, HOLD_TICKS cycles: key_valid=0, the key bit stays set.
- RELEASE, 1 cycle: key_down[code]=0, last_change=code, key_valid=1.
- GAP, GAP_TICKS cycles: all key bits clear, key_valid=0; then LOAD.
- Per-key cost is 2+HOLD_TICKS+GAP_TICKS cycles (7 with defaults).
- Latency: start sampled at edge k puts the first make event on the outputs at cycle k+1.
- DONE: done=1 and busy=0 for one cycle, then IDLE. keys_sent holds its value until the next start.
- At most one key bit is set at any time.
- wordnum=0: SPACE only.
- err_pos >= len: no typo is injected.
- wordnum > MAX_LEN: clamped to MAX_LEN.
- start while busy is ignored. start held high re-triggers from IDLE after each DONE.
- stop:
  - During PRESS or HOLD, force a RELEASE event for the held key next cycle, then DONE.
  - During GAP or LOAD, go to DONE next cycle.
  - stop in IDLE has no effect. stop takes priority over normal sequencing.
- Async rst mid-playback clears key_down at once. No break event is emitted.
- Counters are sized for max(HOLD_TICKS, GAP_TICKS) and saturate to no wrap.

Decomposition:
- Shared package typing_pkg:
  - letter code constants
  - 26-entry scan-code table
  - BACK and SPACE scan codes
  - MAX_LEN
  - ghost-typist state enum

  The counting block and this block share the same table.
- One combinational sub-module, letter_to_scan: 5-bit code in, 7-bit scan code plus valid flag out.

Test Plan:
- word "CAT" (3,1,20), wordnum=3, err_en=0, start pulse at cycle 0:
  - Make events at cycles 1, 8, 15, 22 with last_change 33, 28, 44, 41.
  - Each break event comes 3 cycles after its make.
  - done=1 at cycle 29; keys_sent=4.
- Same word, err_en=1, err_pos=1:
  - Key sequence C, B(50), BACK(102), A, T, SPACE.
  - keys_sent=6; done at cycle 43.
- wordnum=0: single SPACE make/break, done at cycle 8. Code 0 inside a word produces no event and shifts later events 7 cycles earlier.
- stop asserted in the HOLD after the make of 'A':
  - Next cycle: break event for 28, key_down all 0.
  - Cycle after: done=1; no further events.
- Reset mid-HOLD:
  - key_down, key_valid, busy, keys_sent all 0 immediately.
  - A start afterwards replays the word from letter 0.
- start held high, and start re-pulsed while busy:
  - Start pulses while busy are ignored.
  - With start held high, a second playback begins the cycle after done.
  - key_valid is never high in two consecutive cycles.
